// File: rtl/run_detect_pkg.sv
// Shared types and defaults for the programmable consecutive-ones run detector.
package run_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int CW_DEF     = 4;
  localparam int WIN_W_DEF  = 8;
  localparam int HIT_W_DEF  = 8;
  localparam int THRESH_MIN = 1;

endpackage

// File: rtl/run_detect_ctrl_run_counter.sv
// Saturating consecutive-ones counter; flags a hit when the run reaches the threshold.
module run_counter #(
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          w,
  input  logic [CW-1:0] thresh,
  input  logic          overlap,
  input  logic          enable,
  input  logic          clear,
  output logic [CW-1:0] run_cnt,
  output logic          hit
);

  logic [CW-1:0] r_run;
  logic [CW-1:0] w_run_next;
  logic          w_run_max;

  assign w_run_max  = (r_run == {CW{1'b1}});
  assign w_run_next = w ? (w_run_max ? r_run : r_run + CW'(1)) : '0;
  assign hit        = enable && w && (w_run_next >= thresh);
  assign run_cnt    = r_run;

  // Non-overlap mode restarts the run after every hit.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_run <= '0;
    end else if (clear) begin
      r_run <= '0;
    end else if (enable) begin
      r_run <= (hit && !overlap) ? '0 : w_run_next;
    end
  end

endmodule

// File: rtl/run_detect_ctrl.sv
// Configurable run detector: config handshake, self-timed observation window,
// saturating hit count and a report handshake.
module run_detect_ctrl
  import run_detect_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int HIT_W = HIT_W_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_thresh,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             cfg_overlap,
  input  logic             abort,
  input  logic             w,
  output logic             z,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [HIT_W-1:0] rpt_hits,
  output logic             rpt_timeout
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_thresh;
  logic [CW-1:0]    w_cfg_thresh;
  logic [WIN_W-1:0] r_window;
  logic [WIN_W-1:0] r_win_cnt;
  logic             r_overlap;
  logic [HIT_W-1:0] r_hit_cnt;
  logic             r_z;
  logic             r_timeout;
  logic             w_armed;
  logic             w_cfg_accept;
  logic             w_expire;
  logic             w_leave_armed;
  logic             w_hit;
  logic [CW-1:0]    w_run_cnt;

  assign w_cfg_thresh  = (cfg_thresh == '0) ? CW'(THRESH_MIN) : cfg_thresh;
  assign w_armed       = (r_state == ST_ARMED);
  assign w_cfg_accept  = (r_state == ST_IDLE) && cfg_valid;
  assign w_expire      = w_armed && (r_window != '0) && (r_win_cnt == WIN_W'(1));
  assign w_leave_armed = w_armed && (abort || w_expire);

  run_counter #(
    .CW(CW)
  ) u_run_counter (
    .clock   (clock),
    .rst     (rst),
    .w       (w),
    .thresh  (r_thresh),
    .overlap (r_overlap),
    .enable  (w_armed),
    .clear   (w_cfg_accept),
    .run_cnt (w_run_cnt),
    .hit     (w_hit)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (cfg_valid) w_next_state = ST_ARMED;
      ST_ARMED:  if (abort || w_expire) w_next_state = ST_REPORT;
      ST_REPORT: if (rpt_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    rpt_valid = 1'b0;
    case (r_state)
      ST_IDLE:   cfg_ready = 1'b1;
      ST_ARMED:  busy      = 1'b1;
      ST_REPORT: begin
        busy      = 1'b1;
        rpt_valid = 1'b1;
      end
      default:   cfg_ready = 1'b0;
    endcase
  end

  // A zero window never decrements, so only abort can end it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_thresh  <= '0;
      r_window  <= '0;
      r_overlap <= 1'b0;
      r_win_cnt <= '0;
      r_hit_cnt <= '0;
      r_z       <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_z <= w_hit;
      if (w_cfg_accept) begin
        r_thresh  <= w_cfg_thresh;
        r_window  <= cfg_window;
        r_overlap <= cfg_overlap;
        r_win_cnt <= cfg_window;
        r_hit_cnt <= '0;
        r_timeout <= 1'b0;
      end else if (w_armed) begin
        if (r_window != '0) begin
          r_win_cnt <= r_win_cnt - WIN_W'(1);
        end
        if (w_hit && (r_hit_cnt != {HIT_W{1'b1}})) begin
          r_hit_cnt <= r_hit_cnt + HIT_W'(1);
        end
        // Abort takes precedence over a simultaneous expiry.
        if (w_leave_armed) begin
          r_timeout <= !abort;
        end
      end
    end
  end

  assign z           = r_z;
  assign rpt_hits    = r_hit_cnt;
  assign rpt_timeout = r_timeout;

endmodule
